mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_if.sv | 53 +++++
 rtl/mem_req_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter
// and the shared memory port. slave = arbiter view, master = env view.
interface mem_req_arbiter_if;

    // Fetch requester
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    // Load/store requester
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    // Shared read data
    logic [31:0] rsp_rdata;

    // Memory port
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok,
        output rsp_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok,
        input  rsp_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter onto one memory port, one outstanding txn.
// Define MEM_ARB_RR_EN for round-robin on contention (else data wins).
module mem_req_arbiter (
    input  logic               clk,
    input  logic               resetn,
    mem_req_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t state_q;
    state_t state_d;
    logic   owner_q;
    logic   grant_d;
    logic   any_req;

    assign any_req = bus.inst_req | bus.data_req;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    // Contention goes to whoever was not granted last
    always_comb begin
        grant_d = bus.data_req ? OWN_DATA : OWN_INST;
        if (bus.inst_req && bus.data_req) begin
            grant_d = ~last_grant_q;
        end
    end

    // Remember the most recent grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= OWN_INST;
        end else if (state_q == IDLE && any_req) begin
            last_grant_q <= grant_d;
        end
    end
`else
    // Fixed priority: data beats fetch
    always_comb begin
        grant_d = bus.data_req ? OWN_DATA : OWN_INST;
    end
`endif

    // Latch the owner when a transaction starts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= OWN_DATA;
        end else if (state_q == IDLE && any_req) begin
            owner_q <= grant_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ADDR -> DATA -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_req)         state_d = ADDR;
            ADDR: if (bus.mem_addr_ok) state_d = DATA;
            DATA: if (bus.mem_data_ok) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Outputs: route the owner in ADDR, return data in DATA
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_wstrb    = 4'h0;
        bus.mem_addr     = 32'h0;
        bus.mem_wdata    = 32'h0;
        bus.inst_addr_ok = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.rsp_rdata    = 32'h0;
        unique case (state_q)
            ADDR: begin
                bus.mem_req = 1'b1;
                if (owner_q == OWN_DATA) begin
                    bus.mem_wr       = bus.data_wr;
                    bus.mem_wstrb    = bus.data_wstrb;
                    bus.mem_addr     = bus.data_addr;
                    bus.mem_wdata    = bus.data_wdata;
                    bus.data_addr_ok = bus.mem_addr_ok;
                end else begin
                    bus.mem_addr     = bus.inst_addr;
                    bus.inst_addr_ok = bus.mem_addr_ok;
                end
            end
            DATA: begin
                if (bus.mem_data_ok) begin
                    bus.rsp_rdata = bus.mem_rdata;
                    if (owner_q == OWN_DATA) begin
                        bus.data_data_ok = 1'b1;
                    end else begin
                        bus.inst_data_ok = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed cases plus random traffic
// checked against a transaction-level arbitration model.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam bit W_INST = 1'b0;
    localparam bit W_DATA = 1'b1;

    bit last_w = W_INST;
    bit i_pend = 1'b0;
    bit d_pend = 1'b0;

    mem_req_arbiter_if bus();

    mem_req_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Requesters must hold req until their addr_ok
    always @(posedge clk) begin
        if (!resetn) begin
            i_pend <= 1'b0;
            d_pend <= 1'b0;
        end else begin
            assert (!(i_pend && !bus.inst_req)) else begin
                failures++;
                $error("FAIL inst_req_dropped observed=0 expected=1");
            end
            assert (!(d_pend && !bus.data_req)) else begin
                failures++;
                $error("FAIL data_req_dropped observed=0 expected=1");
            end
            i_pend <= bus.inst_req && !bus.inst_addr_ok;
            d_pend <= bus.data_req && !bus.data_addr_ok;
        end
    end

    // Arbitration rule for one grant decision
    task automatic pick(input bit ir, input bit dr, output bit w);
`ifdef MEM_ARB_RR_EN
        if (ir && dr) w = (last_w == W_INST) ? W_DATA : W_INST;
        else          w = dr;
        last_w = w;
`else
        w = dr ? W_DATA : W_INST;
`endif
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ":mem_req"}, bus.mem_req, 0);
        chk({tag, ":mem_wr"}, bus.mem_wr, 0);
        chk({tag, ":mem_wstrb"}, bus.mem_wstrb, 0);
        chk({tag, ":mem_addr"}, bus.mem_addr, 0);
        chk({tag, ":mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, ":inst_addr_ok"}, bus.inst_addr_ok, 0);
        chk({tag, ":data_addr_ok"}, bus.data_addr_ok, 0);
        chk({tag, ":inst_data_ok"}, bus.inst_data_ok, 0);
        chk({tag, ":data_data_ok"}, bus.data_data_ok, 0);
        chk({tag, ":rsp_rdata"}, bus.rsp_rdata, 0);
    endtask

    // Raise new requests; a pending requester keeps its fields
    task automatic new_req(input bit ir, input bit dr);
        if (!ir && !dr && !bus.inst_req && !bus.data_req) ir = 1'b1;
        if (ir && !bus.inst_req) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = $urandom;
        end
        if (dr && !bus.data_req) begin
            bus.data_req   = 1'b1;
            bus.data_wr    = 1'($urandom_range(0, 1));
            bus.data_wstrb = 4'($urandom_range(0, 15));
            bus.data_addr  = $urandom;
            bus.data_wdata = $urandom;
        end
    endtask

    // One transaction starting at an IDLE negedge with reqs applied
    task automatic run_txn(input int aw, input int dw, input bit spur,
                           input logic [31:0] rdv, input string tag);
        bit          w;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ewr;
        logic [3:0]  es;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = spur;
        bus.mem_rdata   = $urandom;
        #1;
        chk({tag, ":idle_mem_req"}, bus.mem_req, 0);
        chk({tag, ":idle_data_ok"},
            {bus.inst_data_ok, bus.data_data_ok}, 0);
        pick(bus.inst_req, bus.data_req, w);
        if (w == W_DATA) begin
            ea = bus.data_addr;
            ed = bus.data_wdata;
            ewr = bus.data_wr;
            es = bus.data_wstrb;
        end else begin
            ea = bus.inst_addr;
            ed = 32'h0;
            ewr = 1'b0;
            es = 4'h0;
        end
        for (int i = 0; i <= aw; i++) begin
            @(negedge clk);
            bus.mem_addr_ok = (i == aw);
            bus.mem_data_ok = spur;
            #1;
            chk({tag, ":mem_req"}, bus.mem_req, 1);
            chk({tag, ":mem_addr"}, bus.mem_addr, ea);
            chk({tag, ":mem_wr"}, bus.mem_wr, ewr);
            chk({tag, ":mem_wstrb"}, bus.mem_wstrb, es);
            chk({tag, ":mem_wdata"}, bus.mem_wdata, ed);
            chk({tag, ":inst_addr_ok"}, bus.inst_addr_ok,
                (i == aw) && (w == W_INST));
            chk({tag, ":data_addr_ok"}, bus.data_addr_ok,
                (i == aw) && (w == W_DATA));
            chk({tag, ":addr_data_ok"},
                {bus.inst_data_ok, bus.data_data_ok}, 0);
        end
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        if (w == W_DATA) bus.data_req = 1'b0;
        else             bus.inst_req = 1'b0;
        for (int i = 0; i <= dw; i++) begin
            if (i > 0) @(negedge clk);
            bus.mem_data_ok = (i == dw);
            bus.mem_rdata   = (i == dw) ? rdv : $urandom;
            #1;
            chk({tag, ":data_mem_req"}, bus.mem_req, 0);
            chk({tag, ":inst_data_ok"}, bus.inst_data_ok,
                (i == dw) && (w == W_INST));
            chk({tag, ":data_data_ok"}, bus.data_data_ok,
                (i == dw) && (w == W_DATA));
            chk({tag, ":rsp_rdata"}, bus.rsp_rdata,
                (i == dw) ? rdv : 32'h0);
        end
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
    endtask

    initial begin
        bus.inst_req    = 1'b0;
        bus.inst_addr   = 32'h0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = 4'h0;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hA5A5A5A5;
        #1;
        check_quiet("reset");
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        resetn = 1'b1;
        #1;
        check_quiet("post_reset");
        @(negedge clk);

        // Single fetch
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C000000;
        run_txn(0, 1, 1'b0, 32'h02800C0C, "fetch");

        // Store
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'h3;
        bus.data_addr  = 32'h80000010;
        bus.data_wdata = 32'hDEADBEEF;
        run_txn(0, 0, 1'b0, 32'h12345678, "store");

        // Spurious response in IDLE and ADDR
        new_req(1'b0, 1'b1);
        run_txn(2, 1, 1'b1, 32'h0BADF00D, "spurious");

        // Backpressure
        new_req(1'b1, 1'b0);
        run_txn(5, 0, 1'b0, 32'h11112222, "backpressure");

        // Contention, both held
        for (int k = 0; k < 4; k++) begin
            new_req(1'b1, 1'b1);
            run_txn(0, 0, 1'b0, $urandom, $sformatf("contend%0d", k));
        end
        run_txn(1, 1, 1'b0, $urandom, "drain");

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            new_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom,
                    $sformatf("rand%0d", k));
        end
        while (bus.inst_req || bus.data_req) begin
            run_txn(0, 0, 1'b0, $urandom, "rand_drain");
        end

        // Reset in DATA abandons the transaction
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h00400000;
        @(negedge clk);
        bus.mem_addr_ok = 1'b1;
        #1;
        chk("rst_txn:inst_addr_ok", bus.inst_addr_ok, 1);
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        bus.inst_req    = 1'b0;
        resetn          = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hFEEDFACE;
        #1;
        check_quiet("rst_in_data");
        last_w = W_INST;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_quiet("rst_release");
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        #1;
        check_quiet("rst_idle");

        // Arbitration resumes after reset
        @(negedge clk);
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = 32'h00001000;
        bus.data_wdata = 32'h0;
        run_txn(0, 2, 1'b0, 32'hCAFE0001, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
